// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO-after-multiply stalls, control
// redirect flushes, multiply-pending tracker and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        uses_rt_D,
  input  logic        mfhilo_D,
  input  logic [4:0]  rf_wa_E,
  input  logic        we_reg_E,
  input  logic        dm2reg_E,
  input  logic        mult_we_E,
  input  logic        jump_E,
  input  logic        jr_sel_E,
  input  logic        branch_taken_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_E,
  output logic        mult_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q;
  logic [3:0]  mcnt_q;
  logic [15:0] stall_cnt_q;

  logic redirect;
  logic load_use;
  logic hilo_wait;
  logic stall;

  assign redirect  = branch_taken_E | jump_E | jr_sel_E;
  // $zero is never a real producer, so it cannot cause a load-use hazard.
  assign load_use  = dm2reg_E & we_reg_E & (rf_wa_E != 5'd0) &
                     ((rf_wa_E == rs_D) | (uses_rt_D & (rf_wa_E == rt_D)));
  assign hilo_wait = mfhilo_D & (mult_busy | mult_we_E);
  assign stall     = (load_use | hilo_wait) & ~redirect;

  assign stall_F   = stall;
  assign stall_D   = stall;
  assign flush_D   = redirect;
  assign flush_E   = redirect | stall;
  assign mult_busy = (state_q == BUSY);
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcnt_q      <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mult_we_E) begin
            mcnt_q  <= 4'(MULT_LAT);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // A new multiply restarts the latency window before any exit check.
          if (mult_we_E) begin
            mcnt_q <= 4'(MULT_LAT);
          end else if (mcnt_q == 4'd1) begin
            mcnt_q  <= 4'd0;
            state_q <= IDLE;
          end else begin
            mcnt_q <= mcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          mcnt_q  <= 4'd0;
        end
      endcase

      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected
// outputs into a queue; a monitor pops and compares them at the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_D, rt_D, rf_wa_E;
  logic        uses_rt_D, mfhilo_D, we_reg_E, dm2reg_E, mult_we_E;
  logic        jump_E, jr_sel_E, branch_taken_E;
  logic        stall_F, stall_D, flush_D, flush_E, mult_busy;
  logic [15:0] stall_cnt;

  typedef struct {
    string       nm;
    logic [20:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_bad;

  hazard_ctrl #(.MULT_LAT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_D           (rs_D),
    .rt_D           (rt_D),
    .uses_rt_D      (uses_rt_D),
    .mfhilo_D       (mfhilo_D),
    .rf_wa_E        (rf_wa_E),
    .we_reg_E       (we_reg_E),
    .dm2reg_E       (dm2reg_E),
    .mult_we_E      (mult_we_E),
    .jump_E         (jump_E),
    .jr_sel_E       (jr_sel_E),
    .branch_taken_E (branch_taken_E),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .mult_busy      (mult_busy),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected {stall_F, stall_D, flush_D, flush_E, mult_busy, stall_cnt}.
  task automatic vec(input string nm,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mfh,
                     input logic [4:0] wa, input logic we, input logic dm,
                     input logic mwe, input logic jmp, input logic jr,
                     input logic br,
                     input logic es, input logic efd, input logic efe,
                     input logic eb, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rs_D = rs; rt_D = rt; uses_rt_D = urt; mfhilo_D = mfh;
    rf_wa_E = wa; we_reg_E = we; dm2reg_E = dm; mult_we_E = mwe;
    jump_E = jmp; jr_sel_E = jr; branch_taken_E = br;
    e.nm  = nm;
    e.exp = {es, es, efd, efe, eb, 16'(ecnt)};
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [20:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {stall_F, stall_D, flush_D, flush_E, mult_busy, stall_cnt};
        n_vec++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got sF=%b sD=%b fD=%b fE=%b busy=%b cnt=%h, required sF=%b sD=%b fD=%b fE=%b busy=%b cnt=%h",
                   e.nm, act[20], act[19], act[18], act[17], act[16], act[15:0],
                   e.exp[20], e.exp[19], e.exp[18], e.exp[17], e.exp[16], e.exp[15:0]);
        end else begin
          $display("vec %s ok cnt=%h busy=%b", e.nm, act[15:0], act[16]);
        end
      end
    end
  end

  initial begin : stim
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rs_D = '0; rt_D = '0; uses_rt_D = 0; mfhilo_D = 0; rf_wa_E = '0;
    we_reg_E = 0; dm2reg_E = 0; mult_we_E = 0; jump_E = 0; jr_sel_E = 0;
    branch_taken_E = 0;

    //  name            rs rt urt mfh wa we dm mwe jmp jr br | st fD fE busy cnt
    vec("reset",         0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   0);
    @(posedge clk); #1; rst_n = 1'b1;
    q.delete();
    // the release above consumed one clock; re-queue the reset-state check
    vec("idle",          0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   0);
    vec("load_use",      5, 0, 0, 0,  5, 1, 1, 0,  0,  0, 0,   1, 0, 1, 0,   0);
    vec("lu_bubble",     5, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   1);
    vec("zero_reg",      0, 0, 0, 0,  0, 1, 1, 0,  0,  0, 0,   0, 0, 0, 0,   1);
    vec("rt_unused",     3, 7, 0, 0,  7, 1, 1, 0,  0,  0, 0,   0, 0, 0, 0,   1);
    vec("rt_used",       3, 7, 1, 0,  7, 1, 1, 0,  0,  0, 0,   1, 0, 1, 0,   1);
    vec("br_over_lu",    5, 0, 0, 0,  5, 1, 1, 0,  0,  0, 1,   0, 1, 1, 0,   2);
    vec("jr_redirect",   0, 0, 0, 0,  0, 0, 0, 0,  0,  1, 0,   0, 1, 1, 0,   2);
    vec("mult_c0",       0, 0, 0, 0,  0, 0, 0, 1,  0,  0, 0,   0, 0, 0, 0,   2);
    vec("mfhilo_c1",     0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   1, 0, 1, 1,   2);
    vec("mfhilo_c2",     0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   1, 0, 1, 1,   3);
    vec("mfhilo_c3",     0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   1, 0, 1, 1,   4);
    vec("mfhilo_c4",     0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   1, 0, 1, 1,   5);
    vec("mfhilo_c5",     0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   6);
    vec("mfhilo_mwe",    0, 0, 0, 1,  0, 0, 0, 1,  0,  0, 0,   1, 0, 1, 0,   6);
    vec("drain_c1",      0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("drain_c2",      0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("drain_c3",      0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("drain_c4",      0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("drain_c5",      0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   7);
    vec("b2b_c0",        0, 0, 0, 0,  0, 0, 0, 1,  0,  0, 0,   0, 0, 0, 0,   7);
    vec("b2b_c1",        0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("b2b_c2",        0, 0, 0, 0,  0, 0, 0, 1,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("b2b_c3",        0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("b2b_c4",        0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("b2b_c5",        0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("b2b_c6",        0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 1,   7);
    vec("b2b_c7",        0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   7);
    vec("mult_again",    0, 0, 0, 0,  0, 0, 0, 1,  0,  0, 0,   0, 0, 0, 0,   7);
    vec("hilo_jump",     0, 0, 0, 1,  0, 0, 0, 0,  1,  0, 0,   0, 1, 1, 1,   7);
    // asynchronous reset in the middle of a pending multiply
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    rs_D = '0; rt_D = '0; uses_rt_D = 0; mfhilo_D = 1; rf_wa_E = '0;
    we_reg_E = 0; dm2reg_E = 0; mult_we_E = 0; jump_E = 0; jr_sel_E = 0;
    branch_taken_E = 0;
    #1;
    n_vec++;
    if ({mult_busy, stall_F, stall_cnt} !== {1'b0, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b stall=%b cnt=%h, required busy=0 stall=0 cnt=0000",
               mult_busy, stall_F, stall_cnt);
    end else begin
      $display("vec async_reset ok busy=%b cnt=%h", mult_busy, stall_cnt);
    end
    vec("in_reset_hilo", 0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   0);
    rst_n = 1'b1;
    vec("post_rst_hilo", 0, 0, 0, 1,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   0);

    // fill the counter to its ceiling with a continuous load-use stall
    for (int i = 0; i < 65535; i++) begin
      vec("sat_fill",    5, 0, 0, 0,  5, 1, 1, 0,  0,  0, 0,   1, 0, 1, 0,   i);
    end
    vec("sat_hold",      5, 0, 0, 0,  5, 1, 1, 0,  0,  0, 0,   1, 0, 1, 0,   65535);
    vec("sat_after",     0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0,   0, 0, 0, 0,   65535);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: MULT_LAT, default 4, multiply result latency in cycles after EX issue (legal 1..15).
REQ-002 The port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 The port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 The port rs_D, input, 5 bits, SHALL carry the rs field of the instruction in decode.
REQ-005 The port rt_D, input, 5 bits, SHALL carry the rt field of the instruction in decode.
REQ-006 The port uses_rt_D, input, 1 bit, SHALL flag that the decode instruction reads rt.
REQ-007 The port mfhilo_D, input, 1 bit, SHALL flag that the decode instruction is MFHI/MFLO.
REQ-008 The port rf_wa_E, input, 5 bits, SHALL carry the execute-stage destination register (rf_jal_wa_out_E).
REQ-009 The ports we_reg_E, dm2reg_E, mult_we_E, jump_E and jr_sel_E, input, 1 bit each, SHALL carry the execute-stage control bits of the same names.
REQ-010 The port branch_taken_E, input, 1 bit, SHALL flag a branch resolved taken in execute.
REQ-011 The ports stall_F and stall_D, output, 1 bit each, SHALL hold the PC and the IF/ID register respectively.
REQ-012 The port flush_D, output, 1 bit, SHALL clear the IF/ID register.
REQ-013 The port flush_E, output, 1 bit, SHALL drive the ID/EX register flush input (bubble insertion).
REQ-014 The port mult_busy, output, 1 bit, SHALL be high while a multiply result is pending.
REQ-015 The port stall_cnt, output, 16 bits, SHALL report the saturating count of stalled cycles.

Function
REQ-016 Multiply tracker state machine SHALL have two states, IDLE and BUSY, and a 4-bit down-counter mcnt.
REQ-017 In IDLE, mult_we_E=1 at a clock edge SHALL load mcnt=MULT_LAT and enter BUSY.
REQ-018 In BUSY, mcnt SHALL decrement by 1 per cycle, and the block SHALL return to IDLE on the edge where mcnt goes 1->0.
REQ-019 In BUSY, mult_we_E=1 SHALL reload mcnt=MULT_LAT, with reload taking priority over decrement and exit.
REQ-020 mult_busy SHALL equal (state==BUSY); it is registered, with no combinational path from inputs.
REQ-021 redirect = branch_taken_E | jump_E | jr_sel_E, combinational.
REQ-022 load_use SHALL equal dm2reg_E & we_reg_E & (rf_wa_E!=0) & ((rf_wa_E==rs_D) | (uses_rt_D & rf_wa_E==rt_D)).
REQ-023 hilo_wait SHALL equal mfhilo_D & (mult_busy | mult_we_E).
REQ-024 stall = (load_use | hilo_wait) & ~redirect.
REQ-025 Outputs SHALL be stall_F=stall_D=stall, flush_D=redirect, and flush_E=redirect|stall; all are combinational with zero latency.
REQ-026 Redirect SHALL win over any simultaneous stall condition: no stall is asserted, and both D and E are flushed.
REQ-027 A load-use stall SHALL last exactly 1 cycle, because the bubble clears dm2reg_E on the next cycle.
REQ-028 hilo_wait SHALL persist until mult_busy falls; MFHI/MFLO SHALL leave decode on the first cycle with state==IDLE and mult_we_E=0.
REQ-029 stall_cnt SHALL increment by 1 on each clock edge where stall=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-030 Register $zero SHALL never create a load-use hazard.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, mcnt=0 and stall_cnt=0, independent of clk.
REQ-032 During reset, stall_F, stall_D, flush_D, flush_E and mult_busy SHALL be 0 unless combinational inputs dictate otherwise; mult_busy is always 0 in reset.
REQ-033 Reset asserted mid-multiply SHALL abandon the pending multiply; after release, a mfhilo_D does not stall unless a new mult_we_E arrives.

Verification
REQ-034 The bench SHALL cover load-use: dm2reg_E=1, we_reg_E=1, rf_wa_E=5, rs_D=5 -> stall_F=stall_D=flush_E=1 for 1 cycle, stall_cnt 0->1.
REQ-035 The bench SHALL cover the $zero and rt-unused cases: rf_wa_E=0 with rs_D=0 -> no stall; rf_wa_E=7, rt_D=7, uses_rt_D=0 -> no stall.
REQ-036 The bench SHALL cover the multiply wait: mult_we_E pulse at cycle 0, mfhilo_D=1 from cycle 1 with MULT_LAT=4 -> mult_busy high for cycles 1..4, stall high cycles 1..4, released at cycle 5.
REQ-037 The bench SHALL cover redirect priority: branch_taken_E=1 together with load_use=1 -> flush_D=1, flush_E=1, stall_F=stall_D=0, stall_cnt unchanged.
REQ-038 The bench SHALL cover back-to-back multiplies: mult_we_E at cycles 0 and 2 -> mult_busy stays high through cycle 6 and falls at cycle 7.
REQ-039 The bench SHALL cover reset and saturation: rst_n pulled low mid-BUSY -> mult_busy=0 asynchronously; a preloaded stall_cnt=16'hFFFF with stall=1 -> stall_cnt stays 16'hFFFF.
